prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream stage of the 8x8 shift-add multiplier.
- Consumes one 16-bit product per handshake and sums a frame of N_TERMS products into a wide accumulator.
- Presents each frame's sum on a valid/ready output for the next stage, e.g. dot-product or filter-tap output logic.
- Holds one finished result and applies back-pressure while the consumer stalls.

Parameters:
- N_TERMS, 4, products per frame; legal range 2 to 256.
- ACC_W, 24, accumulator and sum width in bits; legal range 16 to 32.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  reset: synchronous, active-high.
- clr  input  1  synchronous abort: discards the partial frame or the held result.
- in_valid  input  1  product is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- product  input  16  unsigned product from the multiplier.
- out_valid  output  1  sum and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  ACC_W  unsigned frame sum, saturated.
- overflow  output  1  frame sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=ACCUM, acc=0, cnt=0.
  - Outputs: sum=0, overflow=0, out_valid=0, in_ready=1 on the following cycle.
  - RST overrides every other input, mid-frame or in HOLD.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept fires when in_valid=1: acc <= sat(acc + product), cnt <= cnt+1.
  - Internal sum is ACC_W+1 bits wide. If bit ACC_W is set, acc saturates to all-ones and a sticky ovf flag is set for the rest of the frame.
  - If cnt==N_TERMS-1 when a product is accepted, the next state is HOLD. On that edge sum is loaded with the saturated final value and overflow with ovf.
  - Latency: out_valid rises on the first cycle after the edge that accepted the last product.
- HOLD:
  - in_ready=0, out_valid=1.
  - sum and overflow stay stable until the handshake completes.
  - Products offered while in HOLD are not consumed; the upstream must hold them.
  - If out_ready=1, next state is ACCUM with acc=0, cnt=0, ovf=0. in_ready returns to 1 on the next cycle, giving one bubble per frame.
  - out_valid must not drop before out_ready is seen.
- sum and overflow keep their last values after the handshake and are only meaningful while out_valid=1.
- Gaps in in_valid are legal: terms need not arrive on consecutive cycles, and cnt advances only on accept.
- clr=1:
  - In ACCUM: acc=0, cnt=0, ovf=0. Any product offered that cycle is dropped, since clr wins over in_valid.
  - In HOLD: the result is discarded, out_valid=0 next cycle, state=ACCUM. A simultaneous out_ready is ignored.
- Arithmetic:
  - Unsigned only; product is zero-extended to ACC_W+1 bits.
  - No wrap-around ever appears on sum; it saturates instead.
- cnt is ceil(log2(N_TERMS)) bits wide and never exceeds N_TERMS-1.

Test Plan:
- Reset: assert RST for 2 cycles with in_valid=1 and product=0x1234 -> out_valid=0, sum=0, overflow=0, in_ready=1. No term is counted, so the next frame needs 4 fresh products.
- Basic frame (defaults): products 3, 5, 7, 9 on consecutive cycles -> out_valid=1 one cycle after 9 is accepted, sum=24, overflow=0. Then out_ready=1 -> out_valid=0 and in_ready=1 one cycle later.
- Max operands: 4 x 0xFE01 (255*255) with irregular in_valid gaps of 0, 2 and 1 cycles -> sum=0x3F804 (260100), overflow=0.
- Back-pressure:
  - Complete a frame with out_ready=0 held for 5 cycles, while in_valid=1 and product=100 are offered.
  - Required during the stall: in_ready=0, sum stable, out_valid=1.
  - After out_ready, feed 100, 1, 1, 1 -> second sum=103.
- Abort: accept 50 and 60, then pulse clr together with in_valid (product 70), then feed 1, 1, 1, 1 -> sum=4. Separately, clr in HOLD -> out_valid=0 next cycle and the result is never delivered.
- Saturation (ACC_W=16): feed 0xFFFF, 0x0001, 0x0000, 0x0005 -> sum=0xFFFF, overflow=1. The next frame 1, 1, 1, 1 -> sum=4, overflow=0, confirming the sticky flag clears per frame.

Source files
------------

// File: rtl/prod_accum_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prod_accum_if : product-in / frame-sum-out handshake bundle   (rev 1.0)
// ---------------------------------------------------------------------------
interface prod_accum_if #(
   parameter int ACC_W = 24
);
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      product;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] sum;
   logic             overflow;

   modport master (
      output clr, in_valid, product, out_ready,
      input  in_ready, out_valid, sum, overflow
   );

   modport slave (
      input  clr, in_valid, product, out_ready,
      output in_ready, out_valid, sum, overflow
   );
endinterface
`default_nettype wire

// File: rtl/prod_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prod_accum : saturating sum of N_TERMS 16-bit products per frame   (rev 1.0)
// ---------------------------------------------------------------------------
module prod_accum #(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 24
) (
   input  logic         CLK,
   input  logic         RST,
   prod_accum_if.slave  bus
);
   localparam int                CNT_W    = $clog2(N_TERMS);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_TERMS - 1);
   localparam logic [0:0]        S_ACCUM  = 1'b0;
   localparam logic [0:0]        S_HOLD   = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             overflow_q, overflow_d;

   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] sat_val;
   logic             accept;
   logic             last_term;

   // One spare carry bit; a set carry pins the accumulator at all-ones.
   assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, bus.product};
   assign sat_val   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
   assign accept    = (state_q == S_ACCUM) && bus.in_valid && !bus.clr;
   assign last_term = (cnt_q == LAST_CNT);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      sum_d      = sum_q;
      overflow_d = overflow_q;
      case (state_q)
         S_ACCUM: begin
            if (bus.clr) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (accept) begin
               if (last_term) begin
                  state_d    = S_HOLD;
                  sum_d      = sat_val;
                  overflow_d = ovf_q | sum_ext[ACC_W];
                  acc_d      = '0;
                  cnt_d      = '0;
                  ovf_d      = 1'b0;
               end else begin
                  acc_d = sat_val;
                  cnt_d = cnt_q + 1'b1;
                  ovf_d = ovf_q | sum_ext[ACC_W];
               end
            end
         end
         S_HOLD: begin
            // clr discards the held result even if out_ready is also high.
            if (bus.clr || bus.out_ready) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = S_ACCUM;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         sum_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         sum_q      <= sum_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.sum       = sum_q;
   assign bus.overflow  = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_prod_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prod_accum : directed + random frames on a 24-bit and a 16-bit instance
// ---------------------------------------------------------------------------
module tb_prod_accum;
   localparam int N = 4;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   prod_accum_if #(.ACC_W(24)) ia ();
   prod_accum_if #(.ACC_W(16)) ib ();

   prod_accum #(.N_TERMS(N), .ACC_W(24)) dut_a (.CLK(CLK), .RST(RST), .bus(ia.slave));
   prod_accum #(.N_TERMS(N), .ACC_W(16)) dut_b (.CLK(CLK), .RST(RST), .bus(ib.slave));

   logic        tv_valid [2];
   logic        tv_clr   [2];
   logic        tv_rdy   [2];
   logic [15:0] tv_prod  [2];
   logic        o_in_ready  [2];
   logic        o_out_valid [2];
   logic        o_ovf       [2];
   logic [31:0] o_sum       [2];

   assign ia.in_valid  = tv_valid[0];
   assign ia.clr       = tv_clr[0];
   assign ia.out_ready = tv_rdy[0];
   assign ia.product   = tv_prod[0];
   assign ib.in_valid  = tv_valid[1];
   assign ib.clr       = tv_clr[1];
   assign ib.out_ready = tv_rdy[1];
   assign ib.product   = tv_prod[1];

   assign o_in_ready[0]  = ia.in_ready;
   assign o_out_valid[0] = ia.out_valid;
   assign o_ovf[0]       = ia.overflow;
   assign o_sum[0]       = {8'd0, ia.sum};
   assign o_in_ready[1]  = ib.in_ready;
   assign o_out_valid[1] = ib.out_valid;
   assign o_ovf[1]       = ib.overflow;
   assign o_sum[1]       = {16'd0, ib.sum};

   int          n_cmp = 0;
   int          n_err = 0;
   longint      tot     [2];
   int          cnt     [2];
   logic [63:0] exp_sum [2];
   logic        exp_ovf [2];
   int          acc_w   [2] = '{24, 16};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: a frame's result is the plain sum of its accepted terms, clipped.
   task automatic close_frame(input int w);
      longint mx;
      mx = (longint'(1) << acc_w[w]) - 1;
      exp_sum[w] = (tot[w] > mx) ? 64'(mx) : 64'(tot[w]);
      exp_ovf[w] = (tot[w] > mx);
      tot[w] = 0;
      cnt[w] = 0;
   endtask

   task automatic send(input int w, input logic [15:0] p, input int gap);
      int n;
      n = 0;
      tv_valid[w] = 1'b0;
      repeat (gap) @(negedge CLK);
      tv_valid[w] = 1'b1;
      tv_prod[w]  = p;
      while (!o_in_ready[w] && n < 64) begin
         @(negedge CLK);
         n++;
      end
      chk("in_ready_wait", 64'(o_in_ready[w]), 64'd1);
      @(negedge CLK);
      tv_valid[w] = 1'b0;
      tot[w] += longint'(p);
      cnt[w]++;
      if (cnt[w] == N) begin
         close_frame(w);
         chk("frame_out_valid", 64'(o_out_valid[w]), 64'd1);
         chk("frame_in_ready", 64'(o_in_ready[w]), 64'd0);
         chk("frame_sum", 64'(o_sum[w]), exp_sum[w]);
         chk("frame_overflow", 64'(o_ovf[w]), 64'(exp_ovf[w]));
      end else begin
         chk("mid_out_valid", 64'(o_out_valid[w]), 64'd0);
      end
   endtask

   task automatic recv(input int w, input int stall);
      repeat (stall) begin
         chk("stall_out_valid", 64'(o_out_valid[w]), 64'd1);
         chk("stall_in_ready", 64'(o_in_ready[w]), 64'd0);
         chk("stall_sum", 64'(o_sum[w]), exp_sum[w]);
         @(negedge CLK);
      end
      tv_rdy[w] = 1'b1;
      @(negedge CLK);
      tv_rdy[w] = 1'b0;
      chk("done_out_valid", 64'(o_out_valid[w]), 64'd0);
      chk("done_in_ready", 64'(o_in_ready[w]), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         tv_valid[i] = 1'b1;
         tv_clr[i]   = 1'b0;
         tv_rdy[i]   = 1'b0;
         tv_prod[i]  = 16'h1234;
         tot[i]      = 0;
         cnt[i]      = 0;
         exp_sum[i]  = '0;
         exp_ovf[i]  = 1'b0;
      end
      RST = 1'b1;

      // Reset with a product on offer: nothing may be counted.
      repeat (2) begin
         @(negedge CLK);
         chk("rst_out_valid", 64'(o_out_valid[0]), 64'd0);
         chk("rst_sum", 64'(o_sum[0]), 64'd0);
         chk("rst_overflow", 64'(o_ovf[0]), 64'd0);
         chk("rst_in_ready", 64'(o_in_ready[0]), 64'd1);
      end
      RST = 1'b0;
      tv_valid[0] = 1'b0;
      tv_valid[1] = 1'b0;

      // Basic frame.
      send(0, 16'd3, 0); send(0, 16'd5, 0); send(0, 16'd7, 0); send(0, 16'd9, 0);
      chk("basic_sum_24", 64'(o_sum[0]), 64'd24);
      recv(0, 0);

      // Max operands with irregular gaps.
      send(0, 16'hFE01, 0); send(0, 16'hFE01, 2); send(0, 16'hFE01, 1); send(0, 16'hFE01, 0);
      chk("max_sum", 64'(o_sum[0]), 64'h3F804);
      recv(0, 1);

      // Back-pressure: a product offered during HOLD must wait.
      send(0, 16'd10, 0); send(0, 16'd20, 0); send(0, 16'd30, 0); send(0, 16'd40, 0);
      tv_valid[0] = 1'b1;
      tv_prod[0]  = 16'd100;
      recv(0, 5);
      send(0, 16'd100, 0); send(0, 16'd1, 0); send(0, 16'd1, 0); send(0, 16'd1, 0);
      chk("bp_second_sum", 64'(o_sum[0]), 64'd103);
      recv(0, 0);

      // Abort mid-frame; the clr-cycle product is dropped.
      send(0, 16'd50, 0); send(0, 16'd60, 0);
      tv_clr[0] = 1'b1; tv_valid[0] = 1'b1; tv_prod[0] = 16'd70;
      @(negedge CLK);
      tv_clr[0] = 1'b0; tv_valid[0] = 1'b0;
      tot[0] = 0; cnt[0] = 0;
      chk("clr_acc_out_valid", 64'(o_out_valid[0]), 64'd0);
      send(0, 16'd1, 0); send(0, 16'd1, 0); send(0, 16'd1, 0); send(0, 16'd1, 0);
      chk("clr_acc_sum", 64'(o_sum[0]), 64'd4);
      recv(0, 0);

      // Abort in HOLD, out_ready asserted at the same time.
      send(0, 16'd2, 0); send(0, 16'd2, 0); send(0, 16'd2, 0); send(0, 16'd2, 0);
      tv_clr[0] = 1'b1; tv_rdy[0] = 1'b1;
      @(negedge CLK);
      tv_clr[0] = 1'b0; tv_rdy[0] = 1'b0;
      chk("clr_hold_out_valid", 64'(o_out_valid[0]), 64'd0);
      chk("clr_hold_in_ready", 64'(o_in_ready[0]), 64'd1);
      @(negedge CLK);
      chk("clr_hold_stays_low", 64'(o_out_valid[0]), 64'd0);
      send(0, 16'd1, 0); send(0, 16'd2, 0); send(0, 16'd3, 0); send(0, 16'd4, 0);
      chk("post_clr_sum", 64'(o_sum[0]), 64'd10);
      recv(0, 0);

      // Saturation on the 16-bit instance, then sticky flag must clear.
      send(1, 16'hFFFF, 0); send(1, 16'h0001, 0); send(1, 16'h0000, 0); send(1, 16'h0005, 0);
      chk("sat_sum", 64'(o_sum[1]), 64'hFFFF);
      chk("sat_overflow", 64'(o_ovf[1]), 64'd1);
      recv(1, 0);
      send(1, 16'd1, 0); send(1, 16'd1, 0); send(1, 16'd1, 0); send(1, 16'd1, 0);
      chk("sat_next_sum", 64'(o_sum[1]), 64'd4);
      chk("sat_next_overflow", 64'(o_ovf[1]), 64'd0);
      recv(1, 0);

      // Random frames on both widths.
      for (int f = 0; f < 8; f++) begin
         for (int t = 0; t < N; t++)
            send(0, 16'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 2)));
         recv(0, int'($urandom_range(0, 3)));
         for (int t = 0; t < N; t++)
            send(1, 16'($urandom_range(0, 16'h5000)), int'($urandom_range(0, 2)));
         recv(1, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
